// File: rtl/mem_stage_pipe.sv
// MIPS memory (M) pipeline stage: E/M register, store-data forwarding, byte/half/word
// loads and stores, and a data RAM whose access takes MEM_LAT extra wait cycles.
module mem_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int DM_WORDS = 1024,
    parameter int MEM_LAT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic              valid_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [1:0]        fwd_sel_i,
    input  logic [DATA_W-1:0] wd_w_i,
    input  logic [DATA_W-1:0] pc4_w_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              adel_o,
    output logic              ades_o
);
    localparam int AW = $clog2(DM_WORDS);
    localparam logic [3:0] CNT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [DATA_W-1:0] instr_reg, pc_reg, pc4_reg, alu_reg, rt_reg, wdata_reg;
    logic              valid_reg, rd_reg, wr_reg, sext_reg;
    logic [1:0]        size_reg, fwd_reg;
    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;

    logic              misaligned, op, done, busy, we;
    logic [DATA_W-1:0] fwd_data, store_data, lane_data, word_rd;
    logic [3:0]        be;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [AW-1:0]     idx;

    logic [DATA_W-1:0] mem [DM_WORDS];

    // Pipeline register: holds while the current access is still stalling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_reg <= '0;
            pc_reg    <= '0;
            pc4_reg   <= '0;
            alu_reg   <= '0;
            rt_reg    <= '0;
            valid_reg <= 1'b0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            size_reg  <= 2'd0;
            sext_reg  <= 1'b0;
            fwd_reg   <= 2'd0;
        end else if (!busy) begin
            instr_reg <= instr_i;
            pc_reg    <= pc_i;
            pc4_reg   <= pc4_i;
            alu_reg   <= alu_i;
            rt_reg    <= rt_i;
            valid_reg <= valid_i;
            rd_reg    <= valid_i & mem_rd_i;
            wr_reg    <= valid_i & mem_wr_i;
            size_reg  <= size_i;
            sext_reg  <= sext_i;
            fwd_reg   <= fwd_sel_i;
        end
    end

    always_comb begin
        unique case (size_reg)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = alu_reg[0];
            default: misaligned = (alu_reg[1:0] != 2'd0);
        endcase
    end

    assign op   = (rd_reg | wr_reg) & ~misaligned;
    assign done = (MEM_LAT == 0) || (state_reg == ST_WAIT && cnt_reg == 4'd0);
    assign busy = op & ~done;
    assign we   = op & wr_reg & done;

    always_comb begin
        unique case (fwd_reg)
            2'd1:    fwd_data = wd_w_i;
            2'd2:    fwd_data = pc4_w_i + DATA_W'(4);
            default: fwd_data = rt_reg;
        endcase
    end

    // Store data is sampled in the first M cycle; later wait cycles must not see W-stage changes
    assign store_data = (state_reg == ST_WAIT) ? wdata_reg : fwd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE)
                wdata_reg <= fwd_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (op && MEM_LAT > 0) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0)
                    state_next = ST_IDLE;
                else
                    cnt_next = cnt_reg - 4'd1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Little-endian byte lanes: narrow stores replicate their data across the lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_comb begin
            unique case (size_reg)
                2'd0: begin
                    lane_data[gi*8 +: 8] = store_data[7:0];
                    be[gi]               = (alu_reg[1:0] == 2'(gi));
                end
                2'd1: begin
                    lane_data[gi*8 +: 8] = store_data[(gi%2)*8 +: 8];
                    be[gi]               = (alu_reg[1] == 1'((gi / 2)));
                end
                default: begin
                    lane_data[gi*8 +: 8] = store_data[gi*8 +: 8];
                    be[gi]               = 1'b1;
                end
            endcase
        end
    end

    assign idx = alu_reg[AW+1:2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][b*8 +: 8] <= lane_data[b*8 +: 8];
            end
        end
    end

    assign word_rd = mem[idx];
    assign rd_byte = word_rd[{alu_reg[1:0], 3'b000} +: 8];
    assign rd_half = word_rd[{alu_reg[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = '0;
        if (op && rd_reg) begin
            unique case (size_reg)
                2'd0:    rdata_o = {{(DATA_W-8){sext_reg & rd_byte[7]}}, rd_byte};
                2'd1:    rdata_o = {{(DATA_W-16){sext_reg & rd_half[15]}}, rd_half};
                default: rdata_o = word_rd;
            endcase
        end
    end

    assign instr_o = instr_reg;
    assign pc_o    = pc_reg;
    assign pc4_o   = pc4_reg;
    assign alu_o   = alu_reg;
    assign valid_o = valid_reg & ~busy;
    assign busy_o  = busy;
    assign adel_o  = rd_reg & misaligned;
    assign ades_o  = wr_reg & misaligned;
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: three instances (MEM_LAT 0, 3, 2) share one input bus;
// the driver queues expected results and a monitor checks the active instance's completions.
module tb_mem_stage_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, pc4, alu, rt, wd_w, pc4_w;
    logic        valid, mem_rd, mem_wr, sext;
    logic [1:0]  size, fwd_sel;

    logic [31:0] instr_q [3], pc_q [3], pc4_q [3], alu_q [3], rdata [3];
    logic        valid_q [3], busy [3], adel [3], ades [3];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        adel;
        logic        ades;
        int          stalls;
    } exp_t;

    exp_t        sb [$];
    int          n_cmp = 0, n_fail = 0;
    int          act = 0;
    int          lat [3] = '{0, 3, 2};
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(32), .DM_WORDS(256), .MEM_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset), .instr_i(instr), .pc_i(pc), .pc4_i(pc4), .alu_i(alu), .rt_i(rt),
        .valid_i(valid), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .size_i(size), .sext_i(sext),
        .fwd_sel_i(fwd_sel), .wd_w_i(wd_w), .pc4_w_i(pc4_w), .instr_o(instr_q[0]), .pc_o(pc_q[0]),
        .pc4_o(pc4_q[0]), .alu_o(alu_q[0]), .rdata_o(rdata[0]), .valid_o(valid_q[0]),
        .busy_o(busy[0]), .adel_o(adel[0]), .ades_o(ades[0]));

    mem_stage_pipe #(.DATA_W(32), .DM_WORDS(256), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .instr_i(instr), .pc_i(pc), .pc4_i(pc4), .alu_i(alu), .rt_i(rt),
        .valid_i(valid), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .size_i(size), .sext_i(sext),
        .fwd_sel_i(fwd_sel), .wd_w_i(wd_w), .pc4_w_i(pc4_w), .instr_o(instr_q[1]), .pc_o(pc_q[1]),
        .pc4_o(pc4_q[1]), .alu_o(alu_q[1]), .rdata_o(rdata[1]), .valid_o(valid_q[1]),
        .busy_o(busy[1]), .adel_o(adel[1]), .ades_o(ades[1]));

    mem_stage_pipe #(.DATA_W(32), .DM_WORDS(256), .MEM_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .instr_i(instr), .pc_i(pc), .pc4_i(pc4), .alu_i(alu), .rt_i(rt),
        .valid_i(valid), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .size_i(size), .sext_i(sext),
        .fwd_sel_i(fwd_sel), .wd_w_i(wd_w), .pc4_w_i(pc4_w), .instr_o(instr_q[2]), .pc_o(pc_q[2]),
        .pc4_o(pc4_q[2]), .alu_o(alu_q[2]), .rdata_o(rdata[2]), .valid_o(valid_q[2]),
        .busy_o(busy[2]), .adel_o(adel[2]), .ades_o(ades[2]));

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (inst %0d)", name, got, want, act);
        end
    endfunction

    // Present one instruction, queue its expected completion, return once it has been captured
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sx, input logic [1:0] fs,
                         input logic [31:0] exp_rd, input logic chk_rd,
                         input logic e_adel, input logic e_ades);
        exp_t e;
        int   k;
        pc_ctr  = pc_ctr + 32'd4;
        instr   = {8'hA5, pc_ctr[23:0]};
        pc      = pc_ctr;
        pc4     = pc_ctr + 32'd4;
        alu     = a;
        rt      = d;
        valid   = 1'b1;
        mem_rd  = rd;
        mem_wr  = wr;
        size    = sz;
        sext    = sx;
        fwd_sel = fs;
        e.pc     = pc_ctr;
        e.instr  = instr;
        e.rdata  = exp_rd;
        e.chk_rd = chk_rd;
        e.adel   = e_adel;
        e.ades   = e_ades;
        e.stalls = (e_adel || e_ades) ? 0 : lat[act];
        sb.push_back(e);
        k = 0;
        @(negedge clk);
        while (busy[act] && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL capture_timeout: got busy stuck for %0d cycles required release", k);
        end
        @(posedge clk);
        #1;
        valid  = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                      input logic [1:0] fs, input logic e_ades);
        issue(a, d, 1'b0, 1'b1, sz, 1'b0, fs, 32'd0, 1'b1, 1'b0, e_ades);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                      input logic [31:0] exp_rd, input logic e_adel);
        issue(a, 32'd0, 1'b1, 1'b0, sz, sx, 2'd0, exp_rd, !e_adel, e_adel, 1'b0);
    endtask

    task automatic drain(input int n);
        valid  = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: counts stall cycles and checks each completion against the queue head
    initial begin
        int   stall;
        exp_t e;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall = 0;
            end else begin
                if (busy[act])
                    stall++;
                if (valid_q[act]) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got pc %h required no completion", pc_q[act]);
                    end else begin
                        e = sb.pop_front();
                        chk("pc", pc_q[act], e.pc);
                        chk("instr", instr_q[act], e.instr);
                        if (e.chk_rd)
                            chk("rdata", rdata[act], e.rdata);
                        chk("adel", {31'd0, adel[act]}, {31'd0, e.adel});
                        chk("ades", {31'd0, ades[act]}, {31'd0, e.ades});
                        chk("stall_cycles", stall, e.stalls);
                        $display("xfer inst=%0d pc=%h alu=%h rdata=%h adel=%b ades=%b stall=%0d",
                                 act, pc_q[act], alu_q[act], rdata[act], adel[act], ades[act], stall);
                    end
                    stall = 0;
                end
            end
        end
    end

    initial begin
        int k;
        reset = 1'b0;
        {instr, pc, pc4, alu, rt} = '0;
        {valid, mem_rd, mem_wr, sext} = '0;
        size = 2'd0; fwd_sel = 2'd0;
        wd_w = 32'd0; pc4_w = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", {31'd0, valid_q[i]}, 32'd0);
            chk("reset_busy", {31'd0, busy[i]}, 32'd0);
            chk("reset_pc", pc_q[i], 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        drain(2);

        // Single-cycle access
        act = 0;
        st(32'h10, 32'h1122_3344, 2'd2, 2'd0, 1'b0);
        ld(32'h13, 2'd0, 1'b1, 32'h0000_0011, 1'b0);
        ld(32'h12, 2'd1, 1'b1, 32'h0000_1122, 1'b0);
        ld(32'h10, 2'd0, 1'b0, 32'h0000_0044, 1'b0);
        st(32'h20, 32'hFFFF_FFFF, 2'd2, 2'd0, 1'b0);
        st(32'h21, 32'h0000_00AB, 2'd0, 2'd0, 1'b0);
        ld(32'h20, 2'd2, 1'b0, 32'hFFFF_ABFF, 1'b0);
        ld(32'h21, 2'd0, 1'b1, 32'hFFFF_FFAB, 1'b0);
        ld(32'h21, 2'd0, 1'b0, 32'h0000_00AB, 1'b0);
        st(32'h22, 32'h0000_8001, 2'd1, 2'd0, 1'b0);
        ld(32'h22, 2'd1, 1'b0, 32'h0000_8001, 1'b0);
        ld(32'h22, 2'd1, 1'b1, 32'hFFFF_8001, 1'b0);
        ld(32'h20, 2'd2, 1'b0, 32'h8001_ABFF, 1'b0);
        ld(32'h02, 2'd2, 1'b0, 32'd0, 1'b1);
        st(32'h04, 32'h5566_7788, 2'd2, 2'd0, 1'b0);
        st(32'h05, 32'h0000_9999, 2'd1, 2'd0, 1'b1);
        ld(32'h04, 2'd2, 1'b0, 32'h5566_7788, 1'b0);
        ld(32'h410, 2'd2, 1'b0, 32'h1122_3344, 1'b0);
        drain(8);

        // Three wait cycles per access
        act = 1;
        st(32'h30, 32'h0BAD_F00D, 2'd2, 2'd0, 1'b0);
        ld(32'h30, 2'd2, 1'b0, 32'h0BAD_F00D, 1'b0);
        ld(32'h31, 2'd1, 1'b0, 32'd0, 1'b1);
        ld(32'h32, 2'd1, 1'b0, 32'h0000_0BAD, 1'b0);
        drain(8);

        // Forwarded store data must survive W-stage changes during the stall
        act = 2;
        wd_w = 32'hCAFE_BABE;
        st(32'h40, 32'h1234_5678, 2'd2, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        wd_w = 32'hDEAD_BEEF;
        ld(32'h40, 2'd2, 1'b0, 32'hCAFE_BABE, 1'b0);
        pc4_w = 32'h0000_3004;
        st(32'h44, 32'h0000_0000, 2'd2, 2'd2, 1'b0);
        ld(32'h44, 2'd2, 1'b0, 32'h0000_3008, 1'b0);

        // Reset in the middle of a multi-cycle store aborts it
        st(32'h50, 32'h600D_CAFE, 2'd2, 2'd0, 1'b0);
        ld(32'h50, 2'd2, 1'b0, 32'h600D_CAFE, 1'b0);
        drain(6);
        pc_ctr = pc_ctr + 32'd4;
        pc = pc_ctr; pc4 = pc_ctr + 32'd4; instr = 32'h5555_AAAA;
        alu = 32'h50; rt = 32'hBAD0_BAD0; size = 2'd2; fwd_sel = 2'd0;
        valid = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0; mem_wr = 1'b0;
        chk("abort_busy_before", {31'd0, busy[2]}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_valid", {31'd0, valid_q[2]}, 32'd0);
        chk("abort_busy", {31'd0, busy[2]}, 32'd0);
        chk("abort_pc", pc_q[2], 32'd0);
        chk("abort_alu", alu_q[2], 32'd0);
        chk("abort_ades", {31'd0, ades[2]}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        drain(2);
        ld(32'h50, 2'd2, 1'b0, 32'h600D_CAFE, 1'b0);
        drain(8);

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("pending_at_end", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
